pc_gen: RTL

PC_GEN -- requirements
Module: pc_gen

---
 rtl/pc_gen_pkg.sv | 37 +++
 rtl/pc_gen_redirect_arb.sv | 48 ++++
 rtl/pc_gen.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/pc_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pc_gen_pkg
// Purpose  : Shared CPU definitions for the fetch front end: bus widths,
//            PC generator state encodings and redirect priority codes.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package pc_gen_pkg;

    // Bus widths shared across the pipeline.
    localparam int StallBus   = 6;
    localparam int InsAddrBus = 32;

    // PC generator state encodings.
    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } pc_state_e;

    // Redirect priority codes; a larger code means a higher priority.
    typedef logic [1:0] redir_prio_t;

    localparam redir_prio_t c_PRIO_NONE = 2'd0;
    localparam redir_prio_t c_PRIO_JMP  = 2'd1;
    localparam redir_prio_t c_PRIO_BR   = 2'd2;
    localparam redir_prio_t c_PRIO_TRAP = 2'd3;

    // A stalled redirect may replace a held one only at equal or higher priority.
    function automatic logic prio_overrides(input redir_prio_t fresh,
                                            input redir_prio_t held);
        return (fresh >= held);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pc_gen_redirect_arb.sv
`default_nettype none
// ============================================================================
// Module   : pc_redirect_arb
// Purpose  : Combinational fixed-priority select among the three redirect
//            sources (trap > branch > jump).
// Ports    : trap_en/trap_addr, br_en/br_addr, jmp_en/jmp_addr - requests
//            redir_valid  - any request present
//            redir_addr   - target of the winning request
//            redir_prio   - priority code of the winning request
// Revision : 1.0 - initial release
// ============================================================================
module pc_redirect_arb
    import pc_gen_pkg::*;
#(
    parameter int XLEN = InsAddrBus
) (
    input  logic            trap_en,
    input  logic [XLEN-1:0] trap_addr,
    input  logic            br_en,
    input  logic [XLEN-1:0] br_addr,
    input  logic            jmp_en,
    input  logic [XLEN-1:0] jmp_addr,
    output logic            redir_valid,
    output logic [XLEN-1:0] redir_addr,
    output redir_prio_t     redir_prio
);

    always_comb begin
        redir_valid = 1'b0;
        redir_addr  = '0;
        redir_prio  = c_PRIO_NONE;
        if (trap_en) begin
            redir_valid = 1'b1;
            redir_addr  = trap_addr;
            redir_prio  = c_PRIO_TRAP;
        end else if (br_en) begin
            redir_valid = 1'b1;
            redir_addr  = br_addr;
            redir_prio  = c_PRIO_BR;
        end else if (jmp_en) begin
            redir_valid = 1'b1;
            redir_addr  = jmp_addr;
            redir_prio  = c_PRIO_JMP;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pc_gen.sv
`default_nettype none
// ============================================================================
// Module   : pc_gen
// Purpose  : Program counter generator. Issues sequential fetch addresses,
//            applies trap/branch/jump redirects, and holds a pending
//            redirect while the stage is stalled.
// Ports    : clk        - clock, rising edge
//            rst_n      - synchronous active-low reset
//            stall_i    - stall bus, bit 0 stalls this stage
//            trap_*, br_*, jmp_* - redirect requests and targets
//            pc_ready   - fetch accepts the current pc
//            pc_valid   - pc holds a fetch request
//            pc         - current fetch address (registered)
//            misalign_o - one-cycle pulse on a misaligned redirect
// Macro    : PC_GEN_MISALIGN_CHK_EN - enables misaligned-target detection
//            and the HALT state; without it misalign_o is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int              XLEN    = InsAddrBus,
    parameter logic [XLEN-1:0] PC_RST  = 32'h8000_0000,
    parameter int              STALL_W = StallBus,
    parameter int              STEP    = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [STALL_W-1:0] stall_i,
    input  logic               trap_en,
    input  logic [XLEN-1:0]    trap_addr,
    input  logic               br_en,
    input  logic [XLEN-1:0]    br_addr,
    input  logic               jmp_en,
    input  logic [XLEN-1:0]    jmp_addr,
    input  logic               pc_ready,
    output logic               pc_valid,
    output logic [XLEN-1:0]    pc,
    output logic               misalign_o
);

    localparam logic [XLEN-1:0] c_STEP = XLEN'(STEP);

    pc_state_e       r_state;
    pc_state_e       w_state_nxt;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_pc_nxt;
    logic            r_pend_valid;
    logic            w_pend_valid_nxt;
    logic [XLEN-1:0] r_pend_addr;
    logic [XLEN-1:0] w_pend_addr_nxt;
    redir_prio_t     r_pend_prio;
    redir_prio_t     w_pend_prio_nxt;

    logic            w_redir_valid;
    logic [XLEN-1:0] w_redir_addr;
    redir_prio_t     w_redir_prio;
    logic            w_stall;
    logic            w_apply_valid;
    logic [XLEN-1:0] w_apply_addr;

    // Only bit 0 concerns this stage; the rest belong to later stages.
    logic            w_unused_stall;
    assign w_unused_stall = ^stall_i;
    assign w_stall        = stall_i[0];

    pc_redirect_arb #(
        .XLEN (XLEN)
    ) u_arb (
        .trap_en     (trap_en),
        .trap_addr   (trap_addr),
        .br_en       (br_en),
        .br_addr     (br_addr),
        .jmp_en      (jmp_en),
        .jmp_addr    (jmp_addr),
        .redir_valid (w_redir_valid),
        .redir_addr  (w_redir_addr),
        .redir_prio  (w_redir_prio)
    );

    // A fresh redirect beats a held one; either way the held one is consumed.
    assign w_apply_valid = w_redir_valid | r_pend_valid;
    assign w_apply_addr  = w_redir_valid ? w_redir_addr : r_pend_addr;

    assign pc_valid = (r_state == ST_RUN);
    assign pc       = r_pc;

`ifdef PC_GEN_MISALIGN_CHK_EN
    logic r_misalign;
    logic w_misalign_nxt;
    logic w_apply_mis;
    logic w_trap_mis;

    assign w_apply_mis = ((w_apply_addr % c_STEP) != '0);
    assign w_trap_mis  = ((trap_addr % c_STEP) != '0);
    assign misalign_o  = r_misalign;
`else
    assign misalign_o  = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Next-state / next-value logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_pend_valid_nxt = r_pend_valid;
        w_pend_addr_nxt  = r_pend_addr;
        w_pend_prio_nxt  = r_pend_prio;
`ifdef PC_GEN_MISALIGN_CHK_EN
        w_misalign_nxt   = 1'b0;
`endif
        case (r_state)
            ST_BOOT: begin
                // Redirects are ignored while booting.
                w_state_nxt = ST_RUN;
            end

            ST_RUN: begin
                if (w_stall) begin
                    if (w_redir_valid &&
                        (!r_pend_valid || prio_overrides(w_redir_prio, r_pend_prio))) begin
                        w_pend_valid_nxt = 1'b1;
                        w_pend_addr_nxt  = w_redir_addr;
                        w_pend_prio_nxt  = w_redir_prio;
                    end
                end else begin
                    w_pend_valid_nxt = 1'b0;
                    w_pend_prio_nxt  = c_PRIO_NONE;
                    if (w_apply_valid) begin
`ifdef PC_GEN_MISALIGN_CHK_EN
                        if (w_apply_mis) begin
                            w_misalign_nxt = 1'b1;
                            w_state_nxt    = ST_HALT;
                        end else begin
                            w_pc_nxt = w_apply_addr;
                        end
`else
                        w_pc_nxt = w_apply_addr;
`endif
                    end else if (pc_valid && pc_ready) begin
                        // Wraps modulo 2^XLEN by construction.
                        w_pc_nxt = r_pc + c_STEP;
                    end
                end
            end

`ifdef PC_GEN_MISALIGN_CHK_EN
            ST_HALT: begin
                // Only an aligned trap restarts fetch.
                if (!w_stall && trap_en) begin
                    if (w_trap_mis) begin
                        w_misalign_nxt = 1'b1;
                    end else begin
                        w_pc_nxt    = trap_addr;
                        w_state_nxt = ST_RUN;
                    end
                end
            end
`endif

            default: begin
                w_state_nxt = ST_BOOT;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_BOOT;
            r_pc         <= PC_RST;
            r_pend_valid <= 1'b0;
            r_pend_addr  <= '0;
            r_pend_prio  <= c_PRIO_NONE;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_pend_valid <= w_pend_valid_nxt;
            r_pend_addr  <= w_pend_addr_nxt;
            r_pend_prio  <= w_pend_prio_nxt;
        end
    end

`ifdef PC_GEN_MISALIGN_CHK_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= w_misalign_nxt;
        end
    end
`endif

endmodule
`default_nettype wire
